dec_multip_pipe: RTL and testbench

//   Pipelined unsigned fractional (Q0.8) triple multiplier: y = a*b*c, each operand in [0,255/256].

---
 rtl/dec_multip_pkg.sv | 14 +
 rtl/dec_multip_stage.sv | 43 ++++
 rtl/dec_multip_pipe.sv | 82 ++++++++
 tb/tb_dec_multip_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dec_multip_pkg.sv
// dec_multip_pkg: shared constants for the Q0.DW triple-multiplier pipeline.
//   DW_DEF  : default operand/result width
//   PW1/PW2 : exact product widths after the first and second multiply
//   LATENCY : din_vld sample to dout_vld, in clk cycles
//   RND     : round-half-up constant, weight of the first discarded bit
package dec_multip_pkg;

    localparam int DW_DEF  = 8;
    localparam int PW1     = 2 * DW_DEF;
    localparam int PW2     = 3 * DW_DEF;
    localparam int LATENCY = 2;
    localparam logic [PW2-1:0] RND = PW2'(1) << (2 * DW_DEF - 1);

endpackage

// File: rtl/dec_multip_stage.sv
// dec_multip_stage: one registered unsigned multiply with valid pass-through.
//   clk, rst (async, active-high)
//   a_i [AW], b_i [BW], vld_i : operands and their qualifier
//   p_o [AW+BW], vld_o        : exact registered product and delayed valid
// The product register loads only on vld_i, so idle/X operands never enter it
// and the previous product is held. The valid register updates every cycle.
module dec_multip_stage
    import dec_multip_pkg::*;
#(
    parameter int AW = DW_DEF,
    parameter int BW = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    input  logic             vld_i,
    output logic [AW+BW-1:0] p_o,
    output logic             vld_o
);

    localparam int PW = AW + BW;

    logic [PW-1:0] p_d, p_q;
    logic          vld_q;

    // Widen both operands first so the multiply is exact at PW bits.
    assign p_d = PW'(a_i) * PW'(b_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) p_q <= p_d;
        end
    end

    assign p_o   = p_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/dec_multip_pipe.sv
// dec_multip_pipe: pipelined unsigned Q0.DW triple multiplier, y = a*b*c.
//   clk      : clock, rising edge
//   rstn     : asynchronous reset, ACTIVE-HIGH despite the name
//   din_a/b/c: Q0.DW operands, din_vld qualifies them (no backpressure)
//   dout_y   : Q0.DW result, dout_vld qualifies it; latency 2, throughput 1
// Build option: DEC_MULTIP_ROUND_EN -> round half up and saturate instead of
// truncating. Latency is identical in both builds.
module dec_multip_pipe
    import dec_multip_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    input  logic [DW-1:0] din_c,
    input  logic          din_vld,
    output logic [DW-1:0] dout_y,
    output logic          dout_vld
);

    // Derived from the instance width so non-default DW stays consistent.
    localparam int P1 = 2 * DW;
    localparam int P2 = 3 * DW;

    logic [P1-1:0] p1;
    logic          v1;
    logic [DW-1:0] c1_q;
    logic [P2-1:0] q2;
    logic          v2;

    // Stage 1: a*b, exact.
    dec_multip_stage #(.AW(DW), .BW(DW)) u_s1 (
        .clk   (clk),
        .rst   (rstn),
        .a_i   (din_a),
        .b_i   (din_b),
        .vld_i (din_vld),
        .p_o   (p1),
        .vld_o (v1)
    );

    // c travels alongside the stage-1 product, gated the same way.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)         c1_q <= '0;
        else if (din_vld) c1_q <= din_c;
    end

    // Stage 2: (a*b)*c, exact. Holding q2 while idle is what keeps dout_y.
    dec_multip_stage #(.AW(P1), .BW(DW)) u_s2 (
        .clk   (clk),
        .rst   (rstn),
        .a_i   (p1),
        .b_i   (c1_q),
        .vld_i (v1),
        .p_o   (q2),
        .vld_o (v2)
    );

    assign dout_vld = v2;

`ifdef DEC_MULTIP_ROUND_EN
    localparam logic [P2:0] RND_L = (P2+1)'(1) << (P1 - 1);

    logic [P2:0] sum;
    logic [DW:0] y_wide;

    // One spare bit on the sum catches the carry out of rounding.
    assign sum    = {1'b0, q2} + RND_L;
    assign y_wide = sum[P2:P1];

    always_comb begin
        dout_y = y_wide[DW-1:0];
        if (y_wide[DW]) dout_y = '1;
    end
`else
    // Truncate: drop the 2*DW fractional bits below the Q0.DW result.
    assign dout_y = q2[P2-1:P1];
`endif

endmodule

// File: tb/tb_dec_multip_pipe.sv
// tb_dec_multip_pipe: self-checking bench for dec_multip_pipe.
// Expected results come from plain arithmetic on a*b*c and a scoreboard of
// (due edge, value) entries; outputs are sampled on the falling edge.
module tb_dec_multip_pipe;
    import dec_multip_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din_a, din_b, din_c;
    logic       din_vld;
    logic [7:0] dout_y;
    logic       dout_vld;

    int n_chk  = 0;
    int n_fail = 0;

    dec_multip_pipe #(.DW(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .din_a    (din_a),
        .din_b    (din_b),
        .din_c    (din_c),
        .din_vld  (din_vld),
        .dout_y   (dout_y),
        .dout_vld (dout_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] y;
    } exp_t;

    exp_t       sb[$];
    int         edge_n = 0;
    logic       exp_vld = 1'b0;
    logic [7:0] exp_y   = 8'd0;
    logic [7:0] last_y  = 8'd0;

    function automatic logic [7:0] ref_y(input logic [7:0] a, b, c);
        longint q;
        longint y;
        q = longint'(a) * longint'(b) * longint'(c);
`ifdef DEC_MULTIP_ROUND_EN
        y = (q + 32768) / 65536;
        if (y > 255) y = 255;
`else
        y = q / 65536;
`endif
        return 8'(y);
    endfunction

    // One clock: drive inputs, clock them in, land on the falling edge and
    // work out what the outputs must be now. A sample accepted on edge E is
    // due on the output after edge E+1.
    task automatic step(input logic v, input logic [7:0] a, b, c, input logic xin = 1'b0);
        din_vld = v;
        if (xin) begin
            din_a = 'x; din_b = 'x; din_c = 'x;
        end else begin
            din_a = a; din_b = b; din_c = c;
        end
        @(posedge clk);
        edge_n++;
        if (v && !rstn) sb.push_back('{edge_n + LATENCY - 1, ref_y(a, b, c)});
        @(negedge clk);
        exp_vld = 1'b0;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            exp_vld = 1'b1;
            last_y  = sb[0].y;
            void'(sb.pop_front());
        end
        exp_y = last_y;
    endtask

    task automatic clear_model();
        sb.delete();
        last_y  = 8'd0;
        exp_y   = 8'd0;
        exp_vld = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        clear_model();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            n_chk++;
            if (dout_vld !== 1'b0 || dout_y !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_held: got vld=%b y=%0d, want vld=0 y=0", dout_vld, dout_y);
            end
        end
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            n_chk++;
            if (dout_vld !== 1'b0 || dout_y !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_release_idle: got vld=%b y=%0d, want vld=0 y=0", dout_vld, dout_y);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[7], vb[7], vc[7], want[7];
        logic [7:0] got[$];
        va = '{0, 255, 0, 255, 0, 128, 192};
        vb = '{0, 0, 255, 255, 99, 128, 192};
        vc = '{0, 0, 255, 255, 99, 128, 129};
`ifdef DEC_MULTIP_ROUND_EN
        want = '{0, 0, 0, 253, 0, 32, 73};
`else
        want = '{0, 0, 0, 253, 0, 32, 72};
`endif
        for (int i = 0; i < 9; i++) begin
            if (i < 7) step(1'b1, va[i], vb[i], vc[i]);
            else       step(1'b0, 8'd0, 8'd0, 8'd0);
            n_chk++;
            if (dout_vld !== exp_vld || dout_y !== exp_y) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got vld=%b y=%0d, want vld=%b y=%0d",
                         i, dout_vld, dout_y, exp_vld, exp_y);
            end
            if (dout_vld === 1'b1) got.push_back(dout_y);
        end
        n_chk++;
        if (got.size() != 7) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, want 7", got.size());
        end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL b2b_vec%0d: got %0d, want %0d", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom));
            n_chk++;
            if (dout_vld !== exp_vld || dout_y !== exp_y) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got vld=%b y=%0d, want vld=%b y=%0d",
                         i, dout_vld, dout_y, exp_vld, exp_y);
            end
        end
        for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_drop_hold();
        logic [7:0] a, b, c, last_ref;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom_range(1, 255));
            c = 8'($urandom_range(1, 255));
            last_ref = ref_y(a, b, c);
            step(1'b1, a, b, c);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
            n_chk++;
            if (dout_vld !== (i == 0) || dout_y !== last_ref) begin
                n_fail++;
                $display("FAIL drop_hold_idle%0d: got vld=%b y=%0d, want vld=%b y=%0d",
                         i, dout_vld, dout_y, (i == 0), last_ref);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, b, c;
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'($urandom_range(64, 255)), 8'($urandom_range(64, 255)), 8'($urandom_range(64, 255)));
        #2 rstn = 1'b1;
        #1;
        n_chk++;
        if (dout_vld !== 1'b0 || dout_y !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async: got vld=%b y=%0d, want vld=0 y=0", dout_vld, dout_y);
        end
        clear_model();
        @(negedge clk);
        step(1'b1, 8'd200, 8'd200, 8'd200);
        rstn = 1'b0;
        a = 8'd128; b = 8'd255; c = 8'd200;
        step(1'b1, a, b, c);
        n_chk++;
        if (dout_vld !== 1'b0 || dout_y !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_no_partial: got vld=%b y=%0d, want vld=0 y=0", dout_vld, dout_y);
        end
        step(1'b0, 8'd0, 8'd0, 8'd0);
        n_chk++;
        if (dout_vld !== 1'b1 || dout_y !== ref_y(a, b, c)) begin
            n_fail++;
            $display("FAIL reset_first_valid: got vld=%b y=%0d, want vld=1 y=%0d",
                     dout_vld, dout_y, ref_y(a, b, c));
        end
        step(1'b0, 8'd0, 8'd0, 8'd0);
        n_chk++;
        if (dout_vld !== 1'b0 || dout_y !== exp_y) begin
            n_fail++;
            $display("FAIL reset_after_first: got vld=%b y=%0d, want vld=0 y=%0d", dout_vld, dout_y, exp_y);
        end
    endtask

    initial begin
        rstn    = 1'b1;
        din_vld = 1'b0;
        din_a   = 8'd0;
        din_b   = 8'd0;
        din_c   = 8'd0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_random();
        test_drop_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1);
    end

endmodule
